// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Write-side companion of the instruction memory. It takes a byte stream
//   (valid/ready handshake), packs the bytes little-endian into N-bit words and
//   issues one write strobe per word at sequential addresses 0..DEPTH-1.
//   The core is expected to stay stalled while busy_o=1.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      1-cycle pulse, begins a load at address 0 (IDLE/DONE only)
//   in_valid_i   byte source has data
//   in_byte_i    data byte
//   in_last_i    marks in_byte_i as the final byte of the program
//   in_ready_o   loader accepts a byte this cycle (1 only in LOAD)
//   we_o         write strobe, exactly one cycle per word
//   waddr_o      word address qualified by we_o
//   wdata_o      assembled word qualified by we_o
//   busy_o       1 while loading or writing
//   done_o       held 1 once the load has finished
//   err_o        DEPTH words were written without seeing in_last_i
//   count_o      words written in the current/last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_byte_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [N-1:0]      wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int LANES  = N / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [N-1:0]        asm_q, asm_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [N-1:0]        wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic [N-1:0]        asm_merged;

  // The handshake uses the registered ready flag, so acceptance only ever happens in LOAD.
  assign accept = in_valid_i & ready_q;

  // Current assembly word with the incoming byte dropped into its lane.
  always_comb begin
    asm_merged = asm_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        asm_merged[8*i +: 8] = in_byte_i;
      end else begin
        asm_merged[8*i +: 8] = asm_q[8*i +: 8];
      end
    end
  end

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    last_d  = last_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LOAD;
          lane_d  = '0;
          asm_d   = '0;
          waddr_d = '0;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (accept) begin
          asm_d = asm_merged;
          if ((lane_q == LAST_LANE) || in_last_i) begin
            // Unfilled upper lanes are still zero from the clear, giving zero-padding.
            state_d = S_WRITE;
            wdata_d = asm_merged;
            last_d  = in_last_i;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        count_d = count_q + (ADDR_W+1)'(1);
        if (last_q) begin
          state_d = S_DONE;
        end else if (waddr_q == LAST_ADDR) begin
          // Store is full but the program never ended: truncated.
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_LOAD;
          waddr_d = waddr_q + ADDR_W'(1);
          lane_d  = '0;
          asm_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they come straight out of flops.
  always_comb begin
    ready_d = (state_d == S_LOAD);
    we_d    = (state_d == S_WRITE);
    busy_d  = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      asm_q   <= '0;
      last_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      last_q  <= last_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready_o = ready_q;
  assign we_o       = we_q;
  assign waddr_o    = waddr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int N     = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_last = 1'b0;
  logic          in_ready_o, we_o, busy_o, done_o, err_o;
  logic [AW-1:0] waddr_o;
  logic [N-1:0]  wdata_o;
  logic [AW:0]   count_o;

  imem_loader #(.N(N), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .in_valid_i(in_valid),
    .in_byte_i(in_byte), .in_last_i(in_last), .in_ready_o(in_ready_o),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- word-level behavioural model ----------------
  bit          m_active = 1'b0;   // a load session is running
  bit          m_pend = 1'b0;     // a finished word is being written this cycle
  bit          m_last = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_count = 0;
  int          m_addr = 0;
  logic [31:0] m_data = 32'h0;
  logic [7:0]  m_bytes[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_pend = 1'b0; m_last = 1'b0; m_done = 1'b0;
      m_err = 1'b0; m_count = 0; m_addr = 0; m_data = 32'h0;
      m_bytes.delete();
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_count++;
      if (m_last) begin
        m_active = 1'b0; m_done = 1'b1;
      end else if (m_addr == DEPTH - 1) begin
        m_active = 1'b0; m_done = 1'b1; m_err = 1'b1;
      end else begin
        m_addr++;
      end
    end else if (m_active) begin
      if (in_valid) begin
        m_bytes.push_back(in_byte);
        if (m_bytes.size() == N / 8 || in_last) begin
          m_data = 32'h0;
          for (int i = 0; i < m_bytes.size(); i++) m_data[8*i +: 8] = m_bytes[i];
          m_pend = 1'b1;
          m_last = in_last;
          m_bytes.delete();
        end
      end
    end else if (start) begin
      m_active = 1'b1; m_done = 1'b0; m_err = 1'b0; m_count = 0; m_addr = 0;
      m_bytes.delete();
    end
  end

  // Write log of what the DUT actually strobed.
  logic [AW-1:0] log_a[$];
  logic [31:0]   log_d[$];

  // Per-cycle compare, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    check("we", we_o, m_pend);
    check("in_ready", in_ready_o, m_active && !m_pend);
    check("busy", busy_o, m_active);
    check("done", done_o, m_done);
    check("err", err_o, m_err);
    check("count", count_o, m_count);
    if (m_pend) begin
      check("waddr", waddr_o, m_addr);
      check("wdata", wdata_o, m_data);
    end
    if (we_o === 1'b1) begin
      log_a.push_back(waddr_o);
      log_d.push_back(wdata_o);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] prog[256];

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_byte = b; in_last = last;
    while (!in_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail("accept_wait");
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_prog(input int nbytes, input bit use_last, input bit gaps);
    for (int i = 0; i < nbytes; i++) begin
      if (gaps) begin
        if ($urandom_range(1, 0) == 1) pulse_start();
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      send_byte(prog[i], use_last && (i == nbytes - 1));
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done_o && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) timeout_fail("done_wait");
    @(negedge clk);
  endtask

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_count", count_o, 7'd0);
    check("rst_waddr", waddr_o, 6'd0);
    check("rst_wdata", wdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single word
    clear_log();
    pulse_start();
    prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'hF8;
    send_prog(4, 1'b1, 1'b0);
    wait_done();
    check("t1_nwr", log_a.size(), 1);
    if (log_a.size() >= 1) begin
      check("t1_addr", log_a[0], 6'd0);
      check("t1_data", log_d[0], 32'hF8000000);
    end
    check("t1_done", done_o, 1'b1);
    check("t1_count", count_o, 7'd1);
    check("t1_err", err_o, 1'b0);

    // T2: two words
    clear_log();
    pulse_start();
    prog[4] = 8'h01; prog[5] = 8'h80; prog[6] = 8'h00; prog[7] = 8'hF8;
    send_prog(8, 1'b1, 1'b0);
    wait_done();
    check("t2_nwr", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      check("t2_data0", log_d[0], 32'hF8000000);
      check("t2_addr1", log_a[1], 6'd1);
      check("t2_data1", log_d[1], 32'hF8008001);
    end
    check("t2_count", count_o, 7'd2);

    // T3: short final word is zero-padded
    clear_log();
    pulse_start();
    prog[0] = 8'h1F; prog[1] = 8'h20;
    send_prog(2, 1'b1, 1'b0);
    wait_done();
    check("t3_nwr", log_a.size(), 1);
    if (log_a.size() >= 1) check("t3_data", log_d[0], 32'h0000201F);
    check("t3_done", done_o, 1'b1);

    // T4: overflow, never last
    clear_log();
    for (int i = 0; i < 256; i++) prog[i] = 8'(i);
    pulse_start();
    send_prog(256, 1'b0, 1'b0);
    wait_done();
    check("t4_nwr", log_a.size(), 64);
    if (log_a.size() == 64) begin
      check("t4_data0", log_d[0], 32'h03020100);
      check("t4_addr63", log_a[63], 6'd63);
      check("t4_data63", log_d[63], 32'hFFFEFDFC);
    end
    check("t4_err", err_o, 1'b1);
    check("t4_count", count_o, 7'd64);
    @(negedge clk);
    in_valid = 1'b1; in_byte = 8'h55;
    repeat (4) @(negedge clk);
    check("t4_ready_after", in_ready_o, 1'b0);
    check("t4_count_hold", count_o, 7'd64);
    in_valid = 1'b0;
    clear_log();
    pulse_start();
    @(negedge clk);
    check("t4_restart_err", err_o, 1'b0);
    check("t4_restart_cnt", count_o, 7'd0);
    prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'hF8;
    send_prog(4, 1'b1, 1'b0);
    wait_done();
    check("t4_re_nwr", log_a.size(), 1);
    if (log_a.size() >= 1) check("t4_re_addr", log_a[0], 6'd0);

    // T5: gaps and ignored start pulses
    clear_log();
    for (int i = 0; i < 12; i++) prog[i] = 8'(i + 1);
    pulse_start();
    send_prog(12, 1'b1, 1'b1);
    wait_done();
    check("t5_nwr", log_a.size(), 3);
    if (log_a.size() == 3) begin
      check("t5_data0", log_d[0], 32'h04030201);
      check("t5_data1", log_d[1], 32'h08070605);
      check("t5_data2", log_d[2], 32'h0C0B0A09);
      check("t5_addr2", log_a[2], 6'd2);
    end
    check("t5_count", count_o, 7'd3);

    // T6: reset mid-word
    clear_log();
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy_o, 1'b0);
    check("t6_ready", in_ready_o, 1'b0);
    check("t6_we", we_o, 1'b0);
    check("t6_count", count_o, 7'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("t6_nwr", log_a.size(), 0);
    pulse_start();
    prog[0] = 8'h1F; prog[1] = 8'h20;
    send_prog(2, 1'b1, 1'b0);
    wait_done();
    check("t6_re_nwr", log_a.size(), 1);
    if (log_a.size() >= 1) begin
      check("t6_re_addr", log_a[0], 6'd0);
      check("t6_re_data", log_d[0], 32'h0000201F);
    end
    check("t6_re_count", count_o, 7'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
